// File: rtl/free_list_pkg.sv
// ----------------------------------------------------------------------------
// free_list_pkg
//   Shared sizing and types for the physical-register free list.
//   PHYS_REGS / ARCH_REGS set the register file split; the free ring holds
//   the PHYS_REGS-ARCH_REGS tags that are not architecturally mapped at reset.
//   Ring pointers carry one extra wrap bit so full and empty are distinct.
// ----------------------------------------------------------------------------
package free_list_pkg;

   localparam int PHYS_REGS      = 128;
   localparam int ARCH_REGS      = 64;
   localparam int DISPATCH_WIDTH = 2;
   localparam int COMMIT_WIDTH   = 2;
   localparam int FL_DEPTH       = PHYS_REGS - ARCH_REGS;
   localparam int PRF_W          = $clog2(PHYS_REGS);
   localparam int IDX_W          = $clog2(FL_DEPTH);
   localparam int PTR_W          = IDX_W + 1;

   typedef logic [PRF_W-1:0] prf_idx_t;
   typedef logic [PTR_W-1:0] fl_ptr_t;
   typedef logic [IDX_W-1:0] fl_idx_t;

   // Strip the wrap bit to get the storage slot a pointer refers to
   function automatic fl_idx_t ring_idx(input fl_ptr_t ptr);
      return ptr[IDX_W-1:0];
   endfunction

endpackage

// File: rtl/free_list_if.sv
// ----------------------------------------------------------------------------
// free_list_if
//   Bundle between rename/dispatch + ROB commit (master) and the free list
//   (slave).
//   alloc_req_i      per-lane request for a new PRF
//   alloc_gnt_o      per-lane grant, combinational in the request cycle
//   alloc_prf_o      per-lane PRF, meaningful only where granted
//   free_count_o     registered count of allocatable entries
//   commit_valid_i   ROB commit lane valid
//   commit_rd_wen_i  committed instruction wrote rd
//   commit_old_prf_i PRF released by that commit
//   flush_i          ROB flush
//   error_o          sticky consistency error (0 unless checking is built in)
// ----------------------------------------------------------------------------
interface free_list_if;
   import free_list_pkg::*;

   logic [DISPATCH_WIDTH-1:0]           alloc_req_i;
   logic [DISPATCH_WIDTH-1:0]           alloc_gnt_o;
   prf_idx_t [DISPATCH_WIDTH-1:0]       alloc_prf_o;
   fl_ptr_t                             free_count_o;
   logic [COMMIT_WIDTH-1:0]             commit_valid_i;
   logic [COMMIT_WIDTH-1:0]             commit_rd_wen_i;
   prf_idx_t [COMMIT_WIDTH-1:0]         commit_old_prf_i;
   logic                                flush_i;
   logic                                error_o;

   modport master (
      output alloc_req_i, commit_valid_i, commit_rd_wen_i, commit_old_prf_i, flush_i,
      input  alloc_gnt_o, alloc_prf_o, free_count_o, error_o
   );

   modport slave (
      input  alloc_req_i, commit_valid_i, commit_rd_wen_i, commit_old_prf_i, flush_i,
      output alloc_gnt_o, alloc_prf_o, free_count_o, error_o
   );

endinterface

// File: rtl/free_list_prefix_popcount.sv
// ----------------------------------------------------------------------------
// prefix_popcount
//   For an N-bit vector, gives each bit the number of set bits strictly below
//   it (exclusive prefix count) plus the total. Used to pack sparse alloc and
//   free lanes onto consecutive ring slots.
//   vec     input vector
//   prefix  per-bit exclusive prefix count
//   total   number of set bits
// ----------------------------------------------------------------------------
module prefix_popcount #(
   parameter int N     = 2,
   parameter int CNT_W = $clog2(N + 1)
) (
   input  logic [N-1:0]            vec,
   output logic [N-1:0][CNT_W-1:0] prefix,
   output logic [CNT_W-1:0]        total
);

   logic [CNT_W-1:0] acc_s;

   // Running sum: each bit sees the count accumulated before adding itself
   always_comb begin
      acc_s  = '0;
      prefix = '0;
      for (int i = 0; i < N; i++) begin
         prefix[i] = acc_s;
         acc_s     = acc_s + CNT_W'(vec[i]);
      end
      total = acc_s;
   end

endmodule

// File: rtl/free_list.sv
// ----------------------------------------------------------------------------
// free_list
//   Circular FIFO of free physical register tags for rename/dispatch.
//   Allocation pops from a speculative head; ROB commits push the released
//   old PRF at the tail and advance a retire head. On flush the speculative
//   head snaps back to the retire head, reclaiming uncommitted allocations.
//   clk    clock
//   reset  asynchronous active-high reset
//   fl     free_list_if.slave (alloc, commit, flush, count, error)
//   Optional build macro FREE_LIST_CHECK_EN adds a PHYS_REGS-bit membership
//   vector and a sticky error_o; without it error_o is tied low.
// ----------------------------------------------------------------------------
module free_list
   import free_list_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   free_list_if.slave fl
);

   localparam int A_CNT_W = $clog2(DISPATCH_WIDTH + 1);
   localparam int C_CNT_W = $clog2(COMMIT_WIDTH + 1);

   prf_idx_t entries_r     [FL_DEPTH];
   prf_idx_t entries_nxt_s [FL_DEPTH];
   fl_ptr_t  head_r;
   fl_ptr_t  retire_head_r;
   fl_ptr_t  tail_r;
   fl_ptr_t  free_count_r;
   fl_ptr_t  head_nxt_s;
   fl_ptr_t  retire_head_nxt_s;
   fl_ptr_t  tail_nxt_s;
   fl_ptr_t  count_nxt_s;

   logic [DISPATCH_WIDTH-1:0][A_CNT_W-1:0] alloc_off_s;
   logic [A_CNT_W-1:0]                     alloc_req_total_s;
   logic [A_CNT_W-1:0]                     gnt_total_s;
   logic [DISPATCH_WIDTH-1:0]              alloc_gnt_s;
   prf_idx_t [DISPATCH_WIDTH-1:0]          alloc_prf_s;

   logic [COMMIT_WIDTH-1:0]                free_vld_s;
   logic [COMMIT_WIDTH-1:0][C_CNT_W-1:0]   free_off_s;
   logic [C_CNT_W-1:0]                     free_total_s;

   prefix_popcount #(.N(DISPATCH_WIDTH), .CNT_W(A_CNT_W)) u_alloc_pc (
      .vec    (fl.alloc_req_i),
      .prefix (alloc_off_s),
      .total  (alloc_req_total_s)
   );

   assign free_vld_s = fl.commit_valid_i & fl.commit_rd_wen_i;

   prefix_popcount #(.N(COMMIT_WIDTH), .CNT_W(C_CNT_W)) u_free_pc (
      .vec    (free_vld_s),
      .prefix (free_off_s),
      .total  (free_total_s)
   );

   // Grant lanes whose packed offset falls inside the current free count
   always_comb begin
      alloc_gnt_s = '0;
      alloc_prf_s = '0;
      for (int i = 0; i < DISPATCH_WIDTH; i++) begin
         alloc_gnt_s[i] = fl.alloc_req_i[i] & ~fl.flush_i &
                          (fl_ptr_t'(alloc_off_s[i]) < free_count_r);
         alloc_prf_s[i] = entries_r[ring_idx(head_r + fl_ptr_t'(alloc_off_s[i]))];
      end
   end

   // Grants always form a prefix of the requesting lanes, so their number is
   // min(requests, free count) outside a flush
   always_comb begin
      if (fl.flush_i) begin
         gnt_total_s = '0;
      end else if (fl_ptr_t'(alloc_req_total_s) <= free_count_r) begin
         gnt_total_s = alloc_req_total_s;
      end else begin
         gnt_total_s = A_CNT_W'(free_count_r);
      end
   end

   // Released PRFs land on consecutive tail slots; not visible to alloc
   // until the next cycle
   always_comb begin
      entries_nxt_s = entries_r;
      for (int j = 0; j < COMMIT_WIDTH; j++) begin
         entries_nxt_s[ring_idx(tail_r + fl_ptr_t'(free_off_s[j]))] =
            free_vld_s[j] ? fl.commit_old_prf_i[j]
                          : entries_nxt_s[ring_idx(tail_r + fl_ptr_t'(free_off_s[j]))];
      end
   end

   // Pointer updates; a flush rewinds the speculative head past this
   // cycle's commits
   always_comb begin
      tail_nxt_s        = tail_r + fl_ptr_t'(free_total_s);
      retire_head_nxt_s = retire_head_r + fl_ptr_t'(free_total_s);
      if (fl.flush_i) begin
         head_nxt_s = retire_head_nxt_s;
      end else begin
         head_nxt_s = head_r + fl_ptr_t'(gnt_total_s);
      end
      count_nxt_s = tail_nxt_s - head_nxt_s;
   end

   // Ring storage, pointers and registered free count
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < FL_DEPTH; k++) begin
            entries_r[k] <= prf_idx_t'(ARCH_REGS + k);
         end
         head_r        <= '0;
         retire_head_r <= '0;
         tail_r        <= fl_ptr_t'(FL_DEPTH);
         free_count_r  <= fl_ptr_t'(FL_DEPTH);
      end else begin
         entries_r     <= entries_nxt_s;
         head_r        <= head_nxt_s;
         retire_head_r <= retire_head_nxt_s;
         tail_r        <= tail_nxt_s;
         free_count_r  <= count_nxt_s;
      end
   end

   assign fl.alloc_gnt_o  = alloc_gnt_s;
   assign fl.alloc_prf_o  = alloc_prf_s;
   assign fl.free_count_o = free_count_r;

`ifdef FREE_LIST_CHECK_EN
   logic [PHYS_REGS-1:0] in_list_r;
   logic [PHYS_REGS-1:0] in_list_nxt_s;
   logic [PHYS_REGS-1:0] seen_s;
   logic                 error_r;
   logic                 error_det_s;

   // Membership tracking. Arch PRFs are mapped at reset and so start outside
   // the list; freeing any PRF already present (double free or a PRF that was
   // never handed out) or pushing past a full ring is an error.
   always_comb begin
      seen_s      = in_list_r;
      error_det_s = (free_count_r + fl_ptr_t'(free_total_s)) > fl_ptr_t'(FL_DEPTH);
      for (int j = 0; j < COMMIT_WIDTH; j++) begin
         error_det_s = error_det_s | (free_vld_s[j] & seen_s[fl.commit_old_prf_i[j]]);
         seen_s[fl.commit_old_prf_i[j]] = seen_s[fl.commit_old_prf_i[j]] | free_vld_s[j];
      end
      for (int i = 0; i < DISPATCH_WIDTH; i++) begin
         seen_s[alloc_prf_s[i]] = seen_s[alloc_prf_s[i]] & ~alloc_gnt_s[i];
      end
      in_list_nxt_s = '0;
      if (fl.flush_i) begin
         // Rebuild from the ring slots lying between the new head and tail
         for (int k = 0; k < FL_DEPTH; k++) begin
            in_list_nxt_s[entries_nxt_s[k]] = in_list_nxt_s[entries_nxt_s[k]] |
               (fl_ptr_t'(ring_idx(fl_ptr_t'(k) - head_nxt_s)) < count_nxt_s);
         end
      end else begin
         in_list_nxt_s = seen_s;
      end
   end

   // Membership vector and sticky error flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         in_list_r <= {{FL_DEPTH{1'b1}}, {ARCH_REGS{1'b0}}};
         error_r   <= 1'b0;
      end else begin
         in_list_r <= in_list_nxt_s;
         error_r   <= error_r | error_det_s;
      end
   end

   assign fl.error_o = error_r;
`else
   assign fl.error_o = 1'b0;
`endif

endmodule

// File: tb/tb_free_list.sv
// ----------------------------------------------------------------------------
// tb_free_list
//   Directed scenarios for reset, alloc packing, flush and empty behaviour,
//   plus a randomized run against a queue-based rename/ROB model: the free
//   list is a queue of tags, in-flight allocations a second queue, and an
//   architectural map supplies the old PRF released at each commit.
// ----------------------------------------------------------------------------
module tb_free_list;
   import free_list_pkg::*;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   free_list_if fl_if();

   free_list dut (
      .clk   (clk),
      .reset (reset),
      .fl    (fl_if.slave)
   );

   int checks = 0;
   int errors = 0;

   prf_idx_t    free_q[$];
   prf_idx_t    spec_q[$];
   int          spec_rd[$];
   prf_idx_t    arch_map [ARCH_REGS];
   bit          in_use [PHYS_REGS];

   task automatic drive(input logic [1:0] req, input logic [1:0] cv, input logic [1:0] cwen,
                        input prf_idx_t old0, input prf_idx_t old1, input logic flush_v);
      fl_if.alloc_req_i         = req;
      fl_if.commit_valid_i      = cv;
      fl_if.commit_rd_wen_i     = cwen;
      fl_if.commit_old_prf_i[0] = old0;
      fl_if.commit_old_prf_i[1] = old1;
      fl_if.flush_i             = flush_v;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive(2'b00, 2'b00, 2'b00, 7'd0, 7'd0, 1'b0);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      tick();
   endtask

   task automatic model_reset();
      free_q.delete();
      spec_q.delete();
      spec_rd.delete();
      for (int k = 0; k < FL_DEPTH; k++) free_q.push_back(prf_idx_t'(ARCH_REGS + k));
      for (int a = 0; a < ARCH_REGS; a++) arch_map[a] = prf_idx_t'(a);
      for (int p = 0; p < PHYS_REGS; p++) in_use[p] = (p < ARCH_REGS);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(2'b00, 2'b00, 2'b00, 7'd0, 7'd0, 1'b0);
      #2;
      checks++;
      if (fl_if.free_count_o !== 7'd64) begin
         errors++; $display("FAIL reset_count got %0d want 64", fl_if.free_count_o);
      end
      checks++;
      if (fl_if.alloc_gnt_o !== 2'b00) begin
         errors++; $display("FAIL reset_gnt got %b want 00", fl_if.alloc_gnt_o);
      end
      checks++;
      if (fl_if.error_o !== 1'b0) begin
         errors++; $display("FAIL reset_error got %b want 0", fl_if.error_o);
      end
      do_reset();
      checks++;
      if (fl_if.free_count_o !== 7'd64) begin
         errors++; $display("FAIL reset_count_after got %0d want 64", fl_if.free_count_o);
      end
   endtask

   task automatic test_alloc_pair();
      do_reset();
      drive(2'b11, 2'b00, 2'b00, 7'd0, 7'd0, 1'b0);
      #1;
      checks++;
      if (fl_if.alloc_gnt_o !== 2'b11 || fl_if.alloc_prf_o[0] !== 7'd64 || fl_if.alloc_prf_o[1] !== 7'd65) begin
         errors++; $display("FAIL pair1 got gnt=%b prf=%0d,%0d want 11 64,65",
                            fl_if.alloc_gnt_o, fl_if.alloc_prf_o[0], fl_if.alloc_prf_o[1]);
      end
      tick();
      checks++;
      if (fl_if.free_count_o !== 7'd62) begin
         errors++; $display("FAIL pair1_count got %0d want 62", fl_if.free_count_o);
      end
      #1;
      checks++;
      if (fl_if.alloc_gnt_o !== 2'b11 || fl_if.alloc_prf_o[0] !== 7'd66 || fl_if.alloc_prf_o[1] !== 7'd67) begin
         errors++; $display("FAIL pair2 got gnt=%b prf=%0d,%0d want 11 66,67",
                            fl_if.alloc_gnt_o, fl_if.alloc_prf_o[0], fl_if.alloc_prf_o[1]);
      end
      tick();
      checks++;
      if (fl_if.free_count_o !== 7'd60) begin
         errors++; $display("FAIL pair2_count got %0d want 60", fl_if.free_count_o);
      end
      drive(2'b00, 2'b00, 2'b00, 7'd0, 7'd0, 1'b0);
   endtask

   task automatic test_sparse();
      do_reset();
      drive(2'b10, 2'b00, 2'b00, 7'd0, 7'd0, 1'b0);
      #1;
      checks++;
      if (fl_if.alloc_gnt_o !== 2'b10 || fl_if.alloc_prf_o[1] !== 7'd64) begin
         errors++; $display("FAIL sparse got gnt=%b prf1=%0d want 10 64", fl_if.alloc_gnt_o, fl_if.alloc_prf_o[1]);
      end
      tick();
      drive(2'b01, 2'b00, 2'b00, 7'd0, 7'd0, 1'b0);
      #1;
      checks++;
      if (fl_if.free_count_o !== 7'd63 || fl_if.alloc_gnt_o !== 2'b01 || fl_if.alloc_prf_o[0] !== 7'd65) begin
         errors++; $display("FAIL sparse_next got count=%0d gnt=%b prf0=%0d want 63 01 65",
                            fl_if.free_count_o, fl_if.alloc_gnt_o, fl_if.alloc_prf_o[0]);
      end
      tick();
      drive(2'b00, 2'b00, 2'b00, 7'd0, 7'd0, 1'b0);
   endtask

   task automatic test_flush();
      do_reset();
      drive(2'b11, 2'b00, 2'b00, 7'd0, 7'd0, 1'b0);
      tick();
      tick();
      drive(2'b11, 2'b01, 2'b01, 7'd3, 7'd0, 1'b1);
      #1;
      checks++;
      if (fl_if.alloc_gnt_o !== 2'b00) begin
         errors++; $display("FAIL flush_gnt got %b want 00", fl_if.alloc_gnt_o);
      end
      tick();
      drive(2'b01, 2'b00, 2'b00, 7'd0, 7'd0, 1'b0);
      #1;
      checks++;
      if (fl_if.free_count_o !== 7'd64 || fl_if.alloc_gnt_o !== 2'b01 || fl_if.alloc_prf_o[0] !== 7'd65) begin
         errors++; $display("FAIL flush_after got count=%0d gnt=%b prf0=%0d want 64 01 65",
                            fl_if.free_count_o, fl_if.alloc_gnt_o, fl_if.alloc_prf_o[0]);
      end
      tick();
      drive(2'b00, 2'b00, 2'b00, 7'd0, 7'd0, 1'b0);
   endtask

   task automatic test_drain();
      do_reset();
      drive(2'b11, 2'b00, 2'b00, 7'd0, 7'd0, 1'b0);
      repeat (32) tick();
      drive(2'b11, 2'b01, 2'b01, 7'd7, 7'd0, 1'b0);
      #1;
      checks++;
      if (fl_if.free_count_o !== 7'd0 || fl_if.alloc_gnt_o !== 2'b00) begin
         errors++; $display("FAIL drain_empty got count=%0d gnt=%b want 0 00", fl_if.free_count_o, fl_if.alloc_gnt_o);
      end
      tick();
      drive(2'b11, 2'b00, 2'b00, 7'd0, 7'd0, 1'b0);
      #1;
      checks++;
      if (fl_if.free_count_o !== 7'd1 || fl_if.alloc_gnt_o !== 2'b01 || fl_if.alloc_prf_o[0] !== 7'd7) begin
         errors++; $display("FAIL drain_refill got count=%0d gnt=%b prf0=%0d want 1 01 7",
                            fl_if.free_count_o, fl_if.alloc_gnt_o, fl_if.alloc_prf_o[0]);
      end
      tick();
      drive(2'b00, 2'b00, 2'b00, 7'd0, 7'd0, 1'b0);
   endtask

   task automatic test_async_reset();
      do_reset();
      drive(2'b11, 2'b00, 2'b00, 7'd0, 7'd0, 1'b0);
      repeat (3) tick();
      drive(2'b00, 2'b00, 2'b00, 7'd0, 7'd0, 1'b0);
      #1;
      checks++;
      if (fl_if.free_count_o !== 7'd58) begin
         errors++; $display("FAIL async_pre got %0d want 58", fl_if.free_count_o);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (fl_if.free_count_o !== 7'd64) begin
         errors++; $display("FAIL async_reset_count got %0d want 64", fl_if.free_count_o);
      end
      do_reset();
      drive(2'b01, 2'b00, 2'b00, 7'd0, 7'd0, 1'b0);
      #1;
      checks++;
      if (fl_if.alloc_gnt_o !== 2'b01 || fl_if.alloc_prf_o[0] !== 7'd64) begin
         errors++; $display("FAIL async_reset_head got gnt=%b prf0=%0d want 01 64", fl_if.alloc_gnt_o, fl_if.alloc_prf_o[0]);
      end
      drive(2'b00, 2'b00, 2'b00, 7'd0, 7'd0, 1'b0);
   endtask

   task automatic test_wrap();
      logic [1:0] req;
      logic [1:0] cv;
      logic [1:0] cwen;
      logic [1:0] exp_gnt;
      logic       flush_v;
      prf_idx_t   exp_prf [2];
      prf_idx_t   lane_old [2];
      prf_idx_t   freed[$];
      prf_idx_t   p;
      int         allocated;
      int         cyc;
      int         off;
      int         kind;
      int         rd;
      allocated = 0;
      cyc       = 0;
      do_reset();
      model_reset();
      while (allocated < 200 && cyc < 4000) begin
         cyc++;
         freed.delete();
         req     = 2'($urandom_range(0, 3));
         flush_v = ($urandom_range(0, 15) == 0);
         exp_gnt = 2'b00;
         off     = 0;
         for (int i = 0; i < 2; i++) begin
            exp_prf[i] = 7'd0;
            if (req[i]) begin
               if (off < free_q.size() && !flush_v) begin
                  exp_gnt[i] = 1'b1;
                  exp_prf[i] = free_q[off];
               end
               off++;
            end
         end
         // Each lane: idle, rd-writing commit, non-rd commit, or rd_wen noise on an invalid lane
         for (int l = 0; l < 2; l++) begin
            kind        = $urandom_range(0, 3);
            lane_old[l] = prf_idx_t'($urandom_range(0, PHYS_REGS - 1));
            if (kind == 1 && spec_q.size() > 0) begin
               cv[l] = 1'b1; cwen[l] = 1'b1;
               rd = spec_rd.pop_front();
               p  = spec_q.pop_front();
               lane_old[l]  = arch_map[rd];
               arch_map[rd] = p;
               freed.push_back(lane_old[l]);
            end else if (kind == 2) begin
               cv[l] = 1'b1; cwen[l] = 1'b0;
            end else if (kind == 3) begin
               cv[l] = 1'b0; cwen[l] = 1'b1;
            end else begin
               cv[l] = 1'b0; cwen[l] = 1'b0;
            end
         end
         drive(req, cv, cwen, lane_old[0], lane_old[1], flush_v);
         #1;
         checks++;
         if (fl_if.free_count_o !== fl_ptr_t'(free_q.size()) || fl_if.free_count_o > 7'd64) begin
            errors++; $display("FAIL wrap_count cyc %0d got %0d want %0d", cyc, fl_if.free_count_o, free_q.size());
         end
         checks++;
         if (fl_if.alloc_gnt_o !== exp_gnt) begin
            errors++; $display("FAIL wrap_gnt cyc %0d got %b want %b", cyc, fl_if.alloc_gnt_o, exp_gnt);
         end
         checks++;
         if (fl_if.error_o !== 1'b0) begin
            errors++; $display("FAIL wrap_error cyc %0d got %b want 0", cyc, fl_if.error_o);
         end
         for (int i = 0; i < 2; i++) begin
            if (exp_gnt[i]) begin
               checks++;
               if (fl_if.alloc_prf_o[i] !== exp_prf[i]) begin
                  errors++; $display("FAIL wrap_prf cyc %0d lane %0d got %0d want %0d", cyc, i, fl_if.alloc_prf_o[i], exp_prf[i]);
               end
               p = free_q.pop_front();
               checks++;
               if (in_use[p]) begin
                  errors++; $display("FAIL wrap_unique cyc %0d prf %0d in_use got 1 want 0", cyc, p);
               end
               in_use[p] = 1'b1;
               spec_q.push_back(p);
               spec_rd.push_back($urandom_range(0, ARCH_REGS - 1));
               allocated++;
            end
         end
         foreach (freed[f]) begin
            in_use[freed[f]] = 1'b0;
            free_q.push_back(freed[f]);
         end
         if (flush_v) begin
            for (int i = spec_q.size() - 1; i >= 0; i--) begin
               in_use[spec_q[i]] = 1'b0;
               free_q.push_front(spec_q[i]);
            end
            spec_q.delete();
            spec_rd.delete();
         end
         tick();
      end
      checks++;
      if (allocated < 200) begin
         errors++; $display("FAIL wrap_budget got %0d allocs want 200", allocated);
      end
      drive(2'b00, 2'b00, 2'b00, 7'd0, 7'd0, 1'b0);
      #1;
      checks++;
      if (fl_if.free_count_o !== fl_ptr_t'(free_q.size())) begin
         errors++; $display("FAIL wrap_final_count got %0d want %0d", fl_if.free_count_o, free_q.size());
      end
   endtask

   task automatic test_check();
      logic exp_err;
`ifdef FREE_LIST_CHECK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      do_reset();
      drive(2'b00, 2'b01, 2'b01, 7'd70, 7'd0, 1'b0);
      tick();
      tick();
      drive(2'b00, 2'b00, 2'b00, 7'd0, 7'd0, 1'b0);
      #1;
      checks++;
      if (fl_if.error_o !== exp_err) begin
         errors++; $display("FAIL check_err got %b want %b", fl_if.error_o, exp_err);
      end
      repeat (3) tick();
      checks++;
      if (fl_if.error_o !== exp_err) begin
         errors++; $display("FAIL check_sticky got %b want %b", fl_if.error_o, exp_err);
      end
      do_reset();
      checks++;
      if (fl_if.error_o !== 1'b0) begin
         errors++; $display("FAIL check_cleared got %b want 0", fl_if.error_o);
      end
   endtask

   initial begin
      reset = 1'b1;
      drive(2'b00, 2'b00, 2'b00, 7'd0, 7'd0, 1'b0);
      test_reset();
      test_alloc_pair();
      test_sparse();
      test_flush();
      test_drain();
      test_async_reset();
      test_wrap();
      test_check();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
